softmax_stream_tx: RTL and testbench

- Output-side counterpart of the softmax input stream capture.
- Holds a local buffer of up to 2^INPUTMAX signed words, loaded through an indexed write port.
- On Start, streams words 0..N out, one per accepted handshake, using a Valid/Ready interface with a Last marker.
- Sits between the softmax result stage and the downstream consumer.

---
 rtl/softmax_stream_tx.sv | 128 ++++++++++++
 tb/tb_softmax_stream_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_stream_tx.sv
// Softmax result buffer: indexed write port, streams words 0..N out over Valid/Ready with Last.
// Latency: Start at edge t gives Valid in the next cycle; one word per cycle under continuous Ready.
// Backpressure: Dataout/Valid/Last hold while Ready=0; Start and buffer writes are ignored while Busy.
module softmax_stream_tx #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         WrEn,
    input  logic [INPUTMAX-1:0]          WrAddr,
    input  logic signed [DATALENGTH-1:0] WrData,
    input  logic                         Start,
    input  logic [INPUTMAX-1:0]          N,
    input  logic                         Ready,
    output logic                         Valid,
    output logic                         Last,
    output logic signed [DATALENGTH-1:0] Dataout,
    output logic                         Busy,
    output logic                         Done
);

    localparam int DEPTH = 1 << INPUTMAX;
    localparam logic [INPUTMAX-1:0] IDX_ONE = INPUTMAX'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t                        state_q, state_d;
    logic signed [DATALENGTH-1:0]  mem_q [DEPTH];
    logic [INPUTMAX-1:0]           idx_q, nlat_q;
    logic [INPUTMAX-1:0]           idx_nxt;
    logic signed [DATALENGTH-1:0]  dataout_q;
    logic                          valid_q, last_q;
    logic                          hs, at_end, wr_ok;

    assign hs      = valid_q && Ready;
    assign at_end  = (idx_q == nlat_q);
    assign idx_nxt = idx_q + IDX_ONE;
    assign wr_ok   = (state_q == IDLE) && WrEn;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = STREAM;
            STREAM:  if (hs && at_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            STREAM: Busy = 1'b1;
            DONE: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    // Buffer only accepts writes while idle, so a stream always reads a frozen snapshot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            idx_q     <= '0;
            nlat_q    <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        nlat_q    <= N;
                        idx_q     <= '0;
                        // Same-cycle write to word 0 is forwarded so the first beat is never stale.
                        dataout_q <= (WrEn && (WrAddr == '0)) ? WrData : mem_q[0];
                        valid_q   <= 1'b1;
                        last_q    <= (N == '0);
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (!at_end) begin
                            idx_q     <= idx_nxt;
                            dataout_q <= mem_q[idx_nxt];
                            last_q    <= (idx_nxt == nlat_q);
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Valid   = valid_q;
    assign Last    = last_q;
    assign Dataout = dataout_q;

endmodule

// File: tb/tb_softmax_stream_tx.sv
module tb_softmax_stream_tx;

    localparam int DL    = 32;
    localparam int IM    = 5;
    localparam int DEPTH = 32;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 WrEn;
    logic [IM-1:0]        WrAddr;
    logic signed [DL-1:0] WrData;
    logic                 Start;
    logic [IM-1:0]        N;
    logic                 Ready;
    logic                 Valid;
    logic                 Last;
    logic signed [DL-1:0] Dataout;
    logic                 Busy;
    logic                 Done;

    int errors = 0;
    int checks = 0;

    // Reference: the buffer contents the consumer should see, word by word.
    logic signed [DL-1:0] model_buf [DEPTH];

    always #5 Clock = ~Clock;

    softmax_stream_tx #(.DATALENGTH(DL), .INPUTMAX(IM)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Start   (Start),
        .N       (N),
        .Ready   (Ready),
        .Valid   (Valid),
        .Last    (Last),
        .Dataout (Dataout),
        .Busy    (Busy),
        .Done    (Done)
    );

    task automatic chk(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic wr(input int a, input logic signed [DL-1:0] d);
        WrEn   = 1'b1;
        WrAddr = a[IM-1:0];
        WrData = d;
        @(negedge Clock);
        WrEn = 1'b0;
        model_buf[a] = d;
    endtask

    // mode 0: Ready always high; 1: random Ready; 2: 5 stall cycles then toggling.
    task automatic run_stream(input int n, input int mode, input bit collide, input bit inject);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        Start = 1'b1;
        N     = n[IM-1:0];
        Ready = 1'b0;
        if (collide) begin
            WrEn   = 1'b1;
            WrAddr = '0;
            WrData = 77;
            model_buf[0] = 77;
        end
        @(negedge Clock);
        Start = 1'b0;
        WrEn  = 1'b0;
        chk("start_latency_vld", Valid, 1);
        while (idx <= n && cyc < 2000) begin
            chk("stream_busy", Busy, 1);
            chk("stream_vld", Valid, 1);
            chk("stream_dat", Dataout, model_buf[idx]);
            chk("stream_last", Last, (idx == n) ? 1 : 0);
            chk("stream_done_lo", Done, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = (cyc >= 5) && (cyc % 2 == 1);
            endcase
            WrEn  = 1'b0;
            Start = 1'b0;
            if (inject && cyc == 1) begin
                WrEn   = 1'b1;
                WrAddr = 1;
                WrData = $urandom;
                Start  = 1'b1;
                N      = '0;
            end
            Ready = rdy;
            if (rdy) idx++;
            @(negedge Clock);
            cyc++;
        end
        WrEn  = 1'b0;
        Start = 1'b0;
        Ready = 1'b0;
        if (idx <= n) chk("stream_timeout", idx, n + 1);
        chk("end_vld", Valid, 0);
        chk("end_last", Last, 0);
        chk("done_pulse", Done, 1);
        chk("done_busy", Busy, 1);
        @(negedge Clock);
        chk("done_clear", Done, 0);
        chk("idle_busy", Busy, 0);
        chk("idle_vld", Valid, 0);
    endtask

    initial begin
        Reset  = 1'b0;
        WrEn   = 1'b0;
        WrAddr = '0;
        WrData = '0;
        Start  = 1'b0;
        N      = '0;
        Ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;

        repeat (3) @(negedge Clock);
        chk("rst_vld", Valid, 0);
        chk("rst_busy", Busy, 0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("idle_vld0", Valid, 0);
        chk("idle_last0", Last, 0);
        chk("idle_busy0", Busy, 0);
        chk("idle_done0", Done, 0);
        chk("idle_dat0", Dataout, 0);
        run_stream(0, 0, 1'b0, 1'b0);

        // Basic stream and backpressure over the same four words.
        wr(0, 10);
        wr(1, -20);
        wr(2, 30);
        wr(3, -40);
        run_stream(3, 0, 1'b0, 1'b0);
        run_stream(3, 2, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) wr(i, i * 3);
        run_stream(31, 0, 1'b0, 1'b0);

        run_stream(3, 0, 1'b1, 1'b0);
        run_stream(3, 2, 1'b0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 8; k++) wr($urandom_range(0, DEPTH - 1), $urandom);
            run_stream($urandom_range(0, DEPTH - 1), 1, 1'b0, 1'b0);
        end

        // Reset mid-stream: three handshakes, then stall and abort.
        for (int i = 0; i < 8; i++) wr(i, $urandom);
        Start = 1'b1;
        N     = 7;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pre_rst_dat", Dataout, model_buf[i]);
            Ready = 1'b1;
            @(negedge Clock);
        end
        Ready = 1'b0;
        @(negedge Clock);
        chk("paused_dat", Dataout, model_buf[3]);
        chk("paused_vld", Valid, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_vld", Valid, 0);
        chk("async_rst_last", Last, 0);
        chk("async_rst_busy", Busy, 0);
        chk("async_rst_done", Done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("rst_no_done", Done, 0);
        end
        Reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;
        @(negedge Clock);
        chk("post_rst_done", Done, 0);
        run_stream(0, 0, 1'b0, 1'b0);
        run_stream(31, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
